// File: rtl/lsu_if.sv
// Bundle of the pipeline-side and memory-side handshakes of the load/store unit.
// The slave modport is the LSU's view; the master modport drives the LSU (pipeline plus memory).
interface lsu_if #(
  parameter int XLEN = 64
) ();
  localparam int NB = XLEN / 8;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_wdata;
  logic            in_is_load;
  logic            in_is_store;
  logic [2:0]      in_funct3;
  logic [4:0]      in_rd;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_err;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [NB-1:0]   mem_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_is_load, in_is_store, in_funct3, in_rd,
    output in_ready,
    output out_valid, out_data, out_rd, out_err,
    input  out_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_is_load, in_is_store, in_funct3, in_rd,
    input  in_ready,
    input  out_valid, out_data, out_rd, out_err,
    output out_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit behind the EX-stage ALU: one aligned bus access per
// instruction, sign/zero-extended load return, store ack, or ALU pass-through.
module lsu #(
  parameter int XLEN = 64
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            is_load_q, is_load_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_err_q, out_err_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_wen_q, mem_wen_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]   mem_wstrb_q, mem_wstrb_d;

  logic [3:0]      size_s;
  logic            is_store_s;
  logic            illegal_s;
  logic [OFFW-1:0] in_off_s;
  logic [NB-1:0]   strb_s;
  logic [XLEN-1:0] lane_mask_s;
  logic [XLEN-1:0] wdata_sh_s;
  logic [XLEN-1:0] raw_s;
  logic [XLEN-1:0] keep_s;
  logic            sign_s;
  logic [XLEN-1:0] load_val_s;

  assign bus.in_ready      = (state_q == S_IDLE) && !rst;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_err       = out_err_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wstrb     = mem_wstrb_q;

  // Decode access size, legality and store byte lanes of the incoming instruction.
  always_comb begin
    case (bus.in_funct3[1:0])
      2'd0:    size_s = 4'd1;
      2'd1:    size_s = 4'd2;
      2'd2:    size_s = 4'd4;
      default: size_s = 4'd8;
    endcase
    is_store_s  = bus.in_is_store && !bus.in_is_load;
    in_off_s    = bus.in_addr[OFFW-1:0];
    illegal_s   = ((bus.in_addr[2:0] & 3'(size_s - 4'd1)) != 3'd0)
                || (size_s > 4'(NB))
                || (bus.in_funct3 == 3'b111)
                || (is_store_s && bus.in_funct3[2]);
    strb_s      = NB'((16'd1 << size_s) - 16'd1) << in_off_s;
    lane_mask_s = {XLEN{1'b0}};
    for (int i = 0; i < NB; i++) begin
      lane_mask_s[8*i +: 8] = {8{strb_s[i]}};
    end
    // Lanes outside the strobe are forced to zero so the bus sees deterministic data.
    wdata_sh_s  = (bus.in_wdata << {in_off_s, 3'b000}) & lane_mask_s;
  end

  // Align the returned word and extend it to the access size.
  always_comb begin
    raw_s = bus.mem_rdata >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'd0: begin
        keep_s = XLEN'(8'hFF);
        sign_s = raw_s[7];
      end
      2'd1: begin
        keep_s = XLEN'(16'hFFFF);
        sign_s = raw_s[15];
      end
      2'd2: begin
        keep_s = XLEN'(32'hFFFF_FFFF);
        sign_s = raw_s[31];
      end
      default: begin
        keep_s = {XLEN{1'b1}};
        sign_s = 1'b0;
      end
    endcase
    if (sign_s && !funct3_q[2]) begin
      load_val_s = raw_s | ~keep_s;
    end else begin
      load_val_s = raw_s & keep_s;
    end
  end

  // Next-state logic of the four-phase request/response sequence.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    is_load_d   = is_load_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_err_d   = out_err_q;
    req_valid_d = req_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          off_d     = in_off_s;
          funct3_d  = bus.in_funct3;
          is_load_d = bus.in_is_load;
          out_rd_d  = bus.in_rd;
          if (!bus.in_is_load && !bus.in_is_store) begin
            out_data_d  = bus.in_addr;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (illegal_s) begin
            out_data_d  = {XLEN{1'b0}};
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            req_valid_d = 1'b1;
            mem_addr_d  = {bus.in_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            mem_wen_d   = is_store_s;
            mem_wstrb_d = is_store_s ? strb_s : {NB{1'b0}};
            mem_wdata_d = is_store_s ? wdata_sh_s : {XLEN{1'b0}};
            state_d     = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          req_valid_d = 1'b0;
          mem_addr_d  = {XLEN{1'b0}};
          mem_wen_d   = 1'b0;
          mem_wstrb_d = {NB{1'b0}};
          mem_wdata_d = {XLEN{1'b0}};
          state_d     = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          out_data_d  = is_load_q ? load_val_s : {XLEN{1'b0}};
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = {XLEN{1'b0}};
          out_rd_d    = 5'd0;
          out_err_d   = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including an in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      off_q       <= {OFFW{1'b0}};
      funct3_q    <= 3'd0;
      is_load_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {XLEN{1'b0}};
      out_rd_q    <= 5'd0;
      out_err_q   <= 1'b0;
      req_valid_q <= 1'b0;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= {XLEN{1'b0}};
      mem_wstrb_q <= {NB{1'b0}};
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      is_load_q   <= is_load_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_err_q   <= out_err_d;
      req_valid_q <= req_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes hand-computed results, monitors pop and compare
// whenever out_valid is presented. A 32-bit instance covers the width-dependent error case.
module tb_lsu;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_if #(.XLEN(64)) b64 ();
  lsu_if #(.XLEN(32)) b32 ();
  lsu #(.XLEN(64)) dut   (.clk(clk), .rst(rst), .bus(b64.slave));
  lsu #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t sb32[$];
  bit   seen64 = 1'b0;
  bit   seen32 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor, 64-bit instance.
  always @(negedge clk) begin
    if (b64.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid with no pending result, data %h", b64.out_data);
      end else begin
        if (!seen64) begin
          chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          seen64 = 1'b1;
        end
        chk("out_data", b64.out_data, sb[0].data);
        chk("out_rd", 64'(b64.out_rd), 64'(sb[0].rd));
        chk("out_err", 64'(b64.out_err), 64'(sb[0].err));
        if (b64.out_ready) begin
          void'(sb.pop_front());
          seen64 = 1'b0;
        end
      end
    end
  end

  // Result monitor, 32-bit instance.
  always @(negedge clk) begin
    if (b32.out_valid) begin
      if (sb32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out32: out_valid with no pending result, data %h", b32.out_data);
      end else begin
        if (!seen32) begin
          chk("latency32", 64'(cyc - sb32[0].acc), 64'(sb32[0].lat));
          seen32 = 1'b1;
        end
        chk("out_data32", 64'(b32.out_data), sb32[0].data);
        chk("out_err32", 64'(b32.out_err), 64'(sb32[0].err));
        if (b32.out_ready) begin
          void'(sb32.pop_front());
          seen32 = 1'b0;
        end
      end
    end
  end

  task automatic accept64(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                          input logic [63:0] edata, input logic eerr, input int lat);
    exp_t e;
    b64.in_valid    = 1'b1;
    b64.in_is_load  = ld;
    b64.in_is_store = st;
    b64.in_funct3   = f3;
    b64.in_addr     = addr;
    b64.in_wdata    = wdata;
    b64.in_rd       = rd;
    @(negedge clk);
    chk("in_ready_idle", 64'(b64.in_ready), 64'd1);
    e.data = edata;
    e.rd   = rd;
    e.err  = eerr;
    e.lat  = lat;
    e.acc  = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    b64.in_valid    = 1'b0;
    b64.in_addr     = 64'h0;
    b64.in_wdata    = 64'h0;
  endtask

  task automatic wait_done64();
    int n = 0;
    while (!(b64.out_valid && b64.out_ready) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL timeout: no out_valid/out_ready handshake within 30 cycles");
    end
    @(posedge clk); #1;
    chk("in_ready_after", 64'(b64.in_ready), 64'd1);
  endtask

  task automatic quick64(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [4:0] rd,
                         input logic [63:0] edata, input logic eerr);
    accept64(ld, st, f3, addr, 64'h0, rd, edata, eerr, 1);
    @(negedge clk);
    chk("no_req", 64'(b64.mem_req_valid), 64'd0);
    chk("in_ready_resp", 64'(b64.in_ready), 64'd0);
    @(posedge clk); #1;
    b64.out_ready = 1'b1;
    while (!(b64.out_valid && b64.out_ready) && (cyc < 0)) begin
      @(posedge clk); #1;
    end
    chk("in_ready_after_quick", 64'(b64.in_ready), 64'd1);
  endtask

  task automatic mem64(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                       input logic [63:0] rdata, input logic [63:0] eaddr, input logic ewen,
                       input logic [7:0] estrb, input logic [63:0] ewdata, input logic [63:0] edata,
                       input int req_stall, input int rsp_stall, input int out_stall, input bit noise);
    accept64(ld, st, f3, addr, wdata, rd, edata, 1'b0, 3 + req_stall + rsp_stall);
    if (out_stall > 0) b64.out_ready = 1'b0;
    for (int i = 0; i <= req_stall; i++) begin
      b64.mem_req_ready = (i == req_stall);
      b64.mem_rsp_valid = noise;
      b64.mem_rdata     = noise ? 64'hDEAD_BEEF_DEAD_BEEF : 64'h0;
      @(negedge clk);
      chk("req_valid", 64'(b64.mem_req_valid), 64'd1);
      chk("mem_addr", b64.mem_addr, eaddr);
      chk("mem_wen", 64'(b64.mem_wen), 64'(ewen));
      chk("mem_wstrb", 64'(b64.mem_wstrb), 64'(estrb));
      chk("mem_wdata", b64.mem_wdata, ewdata);
      chk("in_ready_req", 64'(b64.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    b64.mem_req_ready = 1'b0;
    for (int i = 0; i <= rsp_stall; i++) begin
      b64.mem_rsp_valid = (i == rsp_stall);
      b64.mem_rdata     = (i == rsp_stall) ? rdata : 64'h5555_AAAA_5555_AAAA;
      @(negedge clk);
      chk("req_dropped", 64'(b64.mem_req_valid), 64'd0);
      chk("in_ready_wait", 64'(b64.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    b64.mem_rsp_valid = 1'b0;
    b64.mem_rdata     = 64'h0;
    if (out_stall > 0) begin
      repeat (out_stall) begin
        @(negedge clk);
        chk("in_ready_hold", 64'(b64.in_ready), 64'd0);
        @(posedge clk); #1;
      end
      b64.out_ready = 1'b1;
    end
    wait_done64();
  endtask

  initial begin
    rst = 1'b1;
    b64.in_valid = 1'b0; b64.in_is_load = 1'b0; b64.in_is_store = 1'b0;
    b64.in_funct3 = 3'd0; b64.in_addr = 64'h0; b64.in_wdata = 64'h0; b64.in_rd = 5'd0;
    b64.out_ready = 1'b1; b64.mem_req_ready = 1'b0; b64.mem_rsp_valid = 1'b0; b64.mem_rdata = 64'h0;
    b32.in_valid = 1'b0; b32.in_is_load = 1'b0; b32.in_is_store = 1'b0;
    b32.in_funct3 = 3'd0; b32.in_addr = 32'h0; b32.in_wdata = 32'h0; b32.in_rd = 5'd0;
    b32.out_ready = 1'b1; b32.mem_req_ready = 1'b0; b32.mem_rsp_valid = 1'b0; b32.mem_rdata = 32'h0;

    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", 64'(b64.in_ready), 64'd0);
    chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst_out_data", b64.out_data, 64'h0);
    chk("rst_out_rd", 64'(b64.out_rd), 64'd0);
    chk("rst_out_err", 64'(b64.out_err), 64'd0);
    chk("rst_req_valid", 64'(b64.mem_req_valid), 64'd0);
    chk("rst_mem_addr", b64.mem_addr, 64'h0);
    chk("rst_mem_wen", 64'(b64.mem_wen), 64'd0);
    chk("rst_mem_wdata", b64.mem_wdata, 64'h0);
    chk("rst_mem_wstrb", 64'(b64.mem_wstrb), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(b64.in_ready), 64'd1);
    @(posedge clk); #1;

    // Loads: LB, LBU, LW, LWU
    mem64(1'b1, 1'b0, 3'b000, 64'h8000_0000, 64'h0, 5'd1, 64'h1122_3344_5566_77F8,
          64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 1'b0);
    mem64(1'b1, 1'b0, 3'b100, 64'h8000_0000, 64'h0, 5'd2, 64'h1122_3344_5566_77F8,
          64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_00F8, 0, 0, 0, 1'b0);
    mem64(1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'h0, 5'd3, 64'h8765_4321_0000_0000,
          64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 0, 0, 0, 1'b0);
    mem64(1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'h0, 5'd4, 64'h8765_4321_0000_0000,
          64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_8765_4321, 0, 0, 0, 1'b0);
    // Stores: SH, SB with junk upper data, SW in upper half
    mem64(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 0, 0, 0, 1'b0);
    mem64(1'b0, 1'b1, 3'b000, 64'h8000_0001, 64'hDEAD_BEEF_CAFE_F00D, 5'd7, 64'h0,
          64'h8000_0000, 1'b1, 8'h02, 64'h0000_0000_0000_0D00, 64'h0, 0, 0, 0, 1'b0);
    mem64(1'b0, 1'b1, 3'b010, 64'h8000_000C, 64'h1122_3344_5566_7788, 5'd8, 64'h0,
          64'h8000_0008, 1'b1, 8'hF0, 64'h5566_7788_0000_0000, 64'h0, 0, 0, 0, 1'b0);
    // LH at offset 2 with one response stall
    mem64(1'b1, 1'b0, 3'b001, 64'h8000_0002, 64'h0, 5'd10, 64'h0000_0000_8001_0000,
          64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0, 1, 0, 1'b0);
    // Backpressure: 3 request stalls, 2 result stalls, stray responses during REQ
    mem64(1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'h0, 5'd11, 64'h0123_4567_89AB_CDEF,
          64'h8000_0008, 1'b0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 0, 2, 1'b1);

    // Single-cycle results: misaligned, pass-through, bad funct3, unsigned store, misaligned LD
    quick64(1'b1, 1'b0, 3'b001, 64'h8000_0001, 5'd12, 64'h0, 1'b1);
    quick64(1'b0, 1'b0, 3'b000, 64'h0000_0000_0000_1234, 5'd5, 64'h0000_0000_0000_1234, 1'b0);
    quick64(1'b1, 1'b0, 3'b111, 64'h0000_0000_0000_0000, 5'd13, 64'h0, 1'b1);
    quick64(1'b0, 1'b1, 3'b100, 64'h0000_0000_0000_0000, 5'd14, 64'h0, 1'b1);
    quick64(1'b1, 1'b0, 3'b011, 64'h8000_0004, 5'd15, 64'h0, 1'b1);

    // Reset while waiting for the response, then a late response that must be ignored
    accept64(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0, 5'd16, 64'h0, 1'b0, 3);
    b64.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    b64.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(b64.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    seen64 = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", 64'(b64.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("midrst_req_valid", 64'(b64.mem_req_valid), 64'd0);
    @(posedge clk); #1;
    b64.mem_rsp_valid = 1'b1;
    b64.mem_rdata     = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    b64.mem_rsp_valid = 1'b0;
    b64.mem_rdata     = 64'h0;
    repeat (3) begin
      @(negedge clk);
      chk("late_rsp_out_valid", 64'(b64.out_valid), 64'd0);
      chk("late_rsp_in_ready", 64'(b64.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    mem64(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0, 5'd17, 64'hA5A5_5A5A_0F0F_F0F0,
          64'h8000_0010, 1'b0, 8'h00, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0, 0, 1'b0);

    // LD on the 32-bit instance is illegal
    begin
      exp_t e;
      int n;
      b32.in_valid   = 1'b1;
      b32.in_is_load = 1'b1;
      b32.in_funct3  = 3'b011;
      b32.in_addr    = 32'h0000_0000;
      b32.in_rd      = 5'd20;
      @(negedge clk);
      chk("in_ready32", 64'(b32.in_ready), 64'd1);
      e.data = 64'h0; e.rd = 5'd20; e.err = 1'b1; e.lat = 1; e.acc = cyc;
      sb32.push_back(e);
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      @(negedge clk);
      chk("no_req32", 64'(b32.mem_req_valid), 64'd0);
      n = 0;
      while (sb32.size() != 0 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 10) begin
        checks++;
        errors++;
        $display("FAIL timeout32: 32-bit result never consumed");
      end
    end

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expected results never presented", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the EX-stage ALU. Takes the ALU result as an effective address (or as a plain result for non-memory instructions), performs one aligned access on a simple valid/ready memory bus, and returns a sign/zero-extended load value, a store acknowledgement, or the passed-through ALU result to writeback. It handles one instruction at a time, with handshakes on both the pipeline side and the memory side.

## Interface
- XLEN, 64: datapath width; legal values are 32 and 64. Define NB = XLEN/8 and OFFW = log2(NB).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  unit can accept; equals (state==IDLE) && !rst.
- in_addr  in  XLEN  ALU output: the effective address, or the result for non-memory instructions.
- in_wdata  in  XLEN  store data (rs2).
- in_is_load / in_is_store  in  1 / 1  operation kind; both low means pass-through.
- in_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- in_rd  in  5  destination register tag, carried through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts.
- out_data  out  XLEN  load value, pass-through result, or 0 for stores and errors.
- out_rd  out  5  registered copy of in_rd.
- out_err  out  1  misaligned access or illegal width.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_addr  out  XLEN  in_addr with the low OFFW bits cleared.
- mem_wen  out  1  1 = write.
- mem_wdata  out  XLEN  store data shifted into byte lanes.
- mem_wstrb  out  NB  byte enables; 0 for reads.
- mem_rsp_valid  in  1  read data valid or write acknowledged.
- mem_rdata  in  XLEN  full aligned word.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE, accept (in_valid && in_ready): latch addr, wdata, funct3, rd and kind.
  - If neither load nor store: out_data=in_addr, out_err=0, go to RESP.
  - If the access is illegal, go to RESP with out_err=1 and out_data=0. Illegal means: size (1/2/4/8 from funct3[1:0]) does not divide in_addr, or size > NB, or funct3=111, or a store with funct3[2]=1.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1, with mem_addr, mem_wen, mem_wdata and mem_wstrb held stable. On mem_req_ready, go to WAIT.
- WAIT: mem_rsp_valid is sampled only in this state.
  - Load: take raw = mem_rdata >> (8*offset), truncate to the access size, sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1).
  - Store: out_data=0.
  - Then go to RESP.
- RESP: out_valid=1, with out_data, out_rd and out_err stable. On out_ready, go to IDLE. No new instruction is accepted in the same cycle.
- Store lanes:
  - mem_wstrb = ((1<<size)-1) << offset.
  - mem_wdata = in_wdata << (8*offset); lanes outside the strobe are don't-care but must be deterministic (zero).
- mem_rsp_valid outside WAIT and mem_req_ready outside REQ are ignored.

## Timing
- Reset: state IDLE; out_valid, out_err, out_data, out_rd, mem_req_valid, mem_wen, mem_wdata, mem_wstrb and mem_addr all 0. in_ready is 0 during the reset cycle and 1 in the following cycle.
- Pass-through or error: accept in cycle 0, out_valid in cycle 1.
- Memory op, no stalls:
  - cycle 0: accept.
  - cycle 1: mem_req_valid, and mem_req_ready is high.
  - cycle 2: WAIT, mem_rsp_valid is high.
  - cycle 3: out_valid.
- Each stall cycle adds exactly one cycle. The memory response is never consumed in the request-handshake cycle.
- Throughput: at most one instruction per (latency + 1) cycles. in_ready is 0 from the accept cycle until the cycle after the out_ready handshake.
- Reset mid-operation in any state: next cycle is IDLE with all outputs 0 and mem_req_valid dropped. A response that arrives afterwards is ignored.

## Test plan
- LB at 0x8000_0000 with mem_rdata 0x1122_3344_5566_77F8 -> out_data 0xFFFF_FFFF_FFFF_FFF8. LBU at the same address -> 0x0000_0000_0000_00F8. mem_addr is 0x8000_0000 and mem_wstrb is 0 in both cases.
- LW at 0x8000_0004 with mem_rdata 0x8765_4321_0000_0000 -> 0xFFFF_FFFF_8765_4321. LWU -> 0x0000_0000_8765_4321. Latency is exactly 3 cycles with no stalls.
- SH at 0x8000_0006 with in_wdata 0xABCD -> mem_addr 0x8000_0000, mem_wen 1, mem_wstrb 0xC0, mem_wdata[63:48]=0xABCD and all other bits 0. After the ack: out_data 0, out_err 0.
- LH at 0x8000_0001 -> mem_req_valid never asserted, out_valid in cycle 1, out_err 1. Also: funct3=011 with XLEN=32 -> out_err 1. Pass-through of 0x1234 with rd=5 -> out_data 0x1234, out_rd 5, out_valid in cycle 1.
- Backpressure: mem_req_ready low for 3 cycles, then out_ready low for 2 cycles -> every request and result signal is stable while held, in_ready stays 0 throughout, and out_valid first rises in cycle 6.
- rst asserted in WAIT, then mem_rsp_valid pulsed 2 cycles later -> unit stays IDLE, out_valid stays 0, in_ready is 1, and the next LD completes normally.
